spi_master_core: RTL and testbench

// - Single-byte SPI master (mode 0: CPOL=0, CPHA=0, MSB first) serving two slaves over a shared SCLK/MOSI/MISO bus.
// - A host control port strobes one byte and a slave select in; the block shifts 8 bits out on MOSI while shifting 8 bits in from MISO.
// - Received byte and a Ready flag go back to the host. Sits between the system controller and the SPI bus.

---
 rtl/spi_master_core.sv | 111 +++++++++++
 tb/tb_spi_master_core.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_core.sv
// Single-byte SPI mode-0 master for two slaves; Ready after 1+18*HALF_PERIOD cycles.
// Requests arriving while busy, or with no slave selected, are dropped.
module spi_master_core #(
    parameter int HALF_PERIOD = 2
) (
    input  logic       Clk_i,
    input  logic       Rst_i,
    input  logic       strobe,
    input  logic [1:0] ss,
    input  logic [7:0] toXmit,
    output logic [7:0] Rcvd,
    output logic       Ready,
    output logic       busy,
    output logic       SCLK,
    output logic       MOSI,
    input  logic       MISO,
    output logic [1:0] SS_n
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIOD - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [3:0]    half;
    logic          strobe_q;
    logic [7:0]    shreg;
    logic          miso_q;
    logic          accept;
    logic          half_end;
    logic [1:0]    sel_in;

    assign accept   = (state == IDLE) && strobe && !strobe_q && (ss != 2'b00);
    assign half_end = (cnt == CNT_LAST);
    // Both selects requested at once resolves to slave 0.
    assign sel_in   = (ss == 2'b11) ? 2'b01 : ss;

    always_ff @(posedge Clk_i) begin
        if (Rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SETUP;
            SETUP:   if (half_end) state_nx = SHIFT;
            SHIFT:   if (half_end && half == 4'd15) state_nx = HOLD;
            HOLD:    if (half_end) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            strobe_q <= 1'b0;
            cnt      <= '0;
            half     <= '0;
            shreg    <= '0;
            miso_q   <= 1'b0;
            Rcvd     <= '0;
            Ready    <= 1'b0;
            busy     <= 1'b0;
            SCLK     <= 1'b0;
            MOSI     <= 1'b0;
            SS_n     <= 2'b11;
        end else begin
            strobe_q <= strobe;
            if (state == IDLE || half_end) cnt <= '0;
            else                           cnt <= cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg <= toXmit;
                        SS_n  <= ~sel_in;
                        MOSI  <= toXmit[7];
                        Ready <= 1'b0;
                        busy  <= 1'b1;
                        half  <= '0;
                    end
                end
                SHIFT: begin
                    if (half_end) begin
                        half <= half + 1'b1;
                        SCLK <= ~SCLK;
                        // Even half-periods end on a rising SCLK, odd ones on a falling SCLK.
                        if (!half[0]) begin
                            miso_q <= MISO;
                        end else begin
                            shreg <= {shreg[6:0], miso_q};
                            MOSI  <= shreg[6];
                        end
                    end
                end
                DONE: begin
                    SS_n  <= 2'b11;
                    Rcvd  <= shreg;
                    Ready <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_core.sv
// Randomised and directed bench for spi_master_core against a behavioural SPI slave and bus observer.
module tb_spi_master_core;

    localparam int HP      = 2;
    localparam int LATENCY = 1 + 18 * HP;

    logic       clk = 1'b0;
    logic       rst;
    logic       strobe;
    logic [1:0] ss;
    logic [7:0] to_xmit;
    logic [7:0] rcvd;
    logic       ready;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic [1:0] ss_n;

    int errors = 0;
    int checks = 0;

    int         obs_lat;
    int         obs_rises;
    int         obs_ssn_bad;
    int         obs_glitch;
    logic [7:0] obs_mosi;
    logic       obs_ready0;
    logic       obs_busy0;

    always #5 clk = ~clk;

    spi_master_core #(.HALF_PERIOD(HP)) dut (
        .Clk_i (clk),
        .Rst_i (rst),
        .strobe(strobe),
        .ss    (ss),
        .toXmit(to_xmit),
        .Rcvd  (rcvd),
        .Ready (ready),
        .busy  (busy),
        .SCLK  (sclk),
        .MOSI  (mosi),
        .MISO  (miso),
        .SS_n  (ss_n)
    );

    // Runs one request from a falling clock edge and records what the bus did.
    // The slave presents rx MSB first, advancing on each falling SCLK.
    task automatic do_xfer(input logic [7:0] tx, input logic [1:0] s, input logic [7:0] rx,
                           input bit mid_pulse, input bit hold);
        int idx;
        int cyc;
        logic sp;
        logic mp;
        logic [1:0] exp_ssn;
        exp_ssn = (s == 2'b10) ? 2'b01 : 2'b10;
        idx = 0;
        miso = rx[7];
        obs_lat = -1;
        obs_rises = 0;
        obs_ssn_bad = 0;
        obs_glitch = 0;
        obs_mosi = 8'h00;
        to_xmit = tx;
        ss = s;
        strobe = 1'b1;
        @(negedge clk);
        obs_ready0 = ready;
        obs_busy0 = busy;
        if (!hold) strobe = 1'b0;
        sp = sclk;
        mp = mosi;
        cyc = 0;
        while (obs_lat < 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ready) begin
                obs_lat = cyc;
            end else begin
                if (busy && ss_n !== exp_ssn) obs_ssn_bad++;
                if (sclk && !sp) begin
                    obs_rises++;
                    obs_mosi = {obs_mosi[6:0], mosi};
                end
                if (sclk && sp && mosi !== mp) obs_glitch++;
                if (!sclk && sp) begin
                    idx++;
                    miso = (idx < 8) ? rx[3'(7 - idx)] : 1'b0;
                end
                if (mid_pulse && cyc == 10) begin
                    strobe = 1'b1;
                    to_xmit = 8'h00;
                end
                if (mid_pulse && cyc == 11) strobe = 1'b0;
                sp = sclk;
                mp = mosi;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        strobe = 1'b0;
        ss = 2'b00;
        to_xmit = 8'h00;
        miso = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ss_n !== 2'b11) begin errors++; $display("FAIL reset_ss_n got=%b want=11", ss_n); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got=%b want=0", sclk); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", ready); end
        checks++; if (rcvd !== 8'h00) begin errors++; $display("FAIL reset_rcvd got=%h want=00", rcvd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_slave0;
        do_xfer(8'hA5, 2'b01, 8'h3C, 0, 0);
        checks++; if (obs_mosi !== 8'hA5) begin errors++; $display("FAIL s0_mosi got=%h want=a5", obs_mosi); end
        checks++; if (obs_rises != 8) begin errors++; $display("FAIL s0_rises got=%0d want=8", obs_rises); end
        checks++; if (obs_ssn_bad != 0) begin errors++; $display("FAIL s0_ss_n bad_cycles=%0d want=0", obs_ssn_bad); end
        checks++; if (rcvd !== 8'h3C) begin errors++; $display("FAIL s0_rcvd got=%h want=3c", rcvd); end
        checks++; if (obs_lat != LATENCY) begin errors++; $display("FAIL s0_latency got=%0d want=%0d", obs_lat, LATENCY); end
        checks++; if ({obs_ready0, obs_busy0} !== 2'b01) begin errors++; $display("FAIL s0_accept ready,busy got=%b%b want=01", obs_ready0, obs_busy0); end
        checks++; if (obs_glitch != 0) begin errors++; $display("FAIL s0_mosi_stable changes_while_high=%0d want=0", obs_glitch); end
        checks++; if ({ss_n, busy, sclk} !== 4'b1100) begin errors++; $display("FAIL s0_done ss_n,busy,sclk got=%b%b%b want=1100", ss_n, busy, sclk); end
    endtask

    task automatic test_slave1;
        do_xfer(8'hFF, 2'b10, 8'h81, 0, 0);
        checks++; if (obs_mosi !== 8'hFF) begin errors++; $display("FAIL s1_mosi got=%h want=ff", obs_mosi); end
        checks++; if (obs_ssn_bad != 0) begin errors++; $display("FAIL s1_ss_n bad_cycles=%0d want=0", obs_ssn_bad); end
        checks++; if (rcvd !== 8'h81) begin errors++; $display("FAIL s1_rcvd got=%h want=81", rcvd); end
        checks++; if (obs_lat != LATENCY) begin errors++; $display("FAIL s1_latency got=%0d want=%0d", obs_lat, LATENCY); end
    endtask

    task automatic test_ignored;
        int sclk_hi;
        int busy_hi;
        logic [7:0] keep;
        do_xfer(8'hC3, 2'b01, 8'h5E, 1, 0);
        checks++; if (obs_mosi !== 8'hC3) begin errors++; $display("FAIL midstrobe_mosi got=%h want=c3", obs_mosi); end
        checks++; if (rcvd !== 8'h5E) begin errors++; $display("FAIL midstrobe_rcvd got=%h want=5e", rcvd); end
        checks++; if (obs_lat != LATENCY) begin errors++; $display("FAIL midstrobe_latency got=%0d want=%0d", obs_lat, LATENCY); end
        keep = rcvd;
        ss = 2'b00;
        to_xmit = 8'h77;
        strobe = 1'b1;
        sclk_hi = 0;
        busy_hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 1) strobe = 1'b0;
            if (sclk) sclk_hi++;
            if (busy) busy_hi++;
        end
        checks++; if (sclk_hi + busy_hi != 0) begin errors++; $display("FAIL ss00_activity sclk_hi=%0d busy_hi=%0d want=0", sclk_hi, busy_hi); end
        checks++; if (ready !== 1'b1 || rcvd !== keep) begin errors++; $display("FAIL ss00_unchanged ready=%b rcvd=%h want=1 %h", ready, rcvd, keep); end
    endtask

    task automatic test_hold_and_ss11;
        int busy_hi;
        do_xfer(8'h3A, 2'b11, 8'h96, 0, 1);
        checks++; if (obs_ssn_bad != 0) begin errors++; $display("FAIL ss11_ss_n bad_cycles=%0d want=0", obs_ssn_bad); end
        checks++; if (rcvd !== 8'h96 || obs_mosi !== 8'h3A) begin errors++; $display("FAIL ss11_data rcvd=%h mosi=%h want=96 3a", rcvd, obs_mosi); end
        busy_hi = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) busy_hi++;
        end
        checks++; if (busy_hi != 0 || ready !== 1'b1) begin errors++; $display("FAIL held_strobe busy_cycles=%0d ready=%b want=0 1", busy_hi, ready); end
        strobe = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        do_xfer(8'h12, 2'b10, 8'hE7, 0, 0);
        checks++; if (rcvd !== 8'hE7) begin errors++; $display("FAIL b2b_first_rcvd got=%h want=e7", rcvd); end
        do_xfer(8'h5A, 2'b01, 8'hC6, 0, 0);
        checks++; if (obs_ready0 !== 1'b0 || obs_busy0 !== 1'b1) begin errors++; $display("FAIL b2b_accept ready=%b busy=%b want=0 1", obs_ready0, obs_busy0); end
        checks++; if (rcvd !== 8'hC6 || obs_mosi !== 8'h5A) begin errors++; $display("FAIL b2b_data rcvd=%h mosi=%h want=c6 5a", rcvd, obs_mosi); end
        checks++; if (obs_lat != LATENCY) begin errors++; $display("FAIL b2b_latency got=%0d want=%0d", obs_lat, LATENCY); end
    endtask

    task automatic test_random;
        logic [7:0] tx;
        logic [7:0] rx;
        logic [1:0] s;
        for (int n = 0; n < 8; n++) begin
            tx = 8'($urandom);
            rx = 8'($urandom);
            s  = 2'($urandom_range(1, 3));
            do_xfer(tx, s, rx, 0, 0);
            checks++;
            if (obs_mosi !== tx || rcvd !== rx || obs_lat != LATENCY || obs_ssn_bad != 0 || obs_rises != 8) begin
                errors++;
                $display("FAIL rand%0d mosi=%h rcvd=%h lat=%0d ssn_bad=%0d rises=%0d want=%h %h %0d 0 8",
                         n, obs_mosi, rcvd, obs_lat, obs_ssn_bad, obs_rises, tx, rx, LATENCY);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        do_xfer(8'h44, 2'b01, 8'h00, 0, 0);
        checks++; if (rcvd !== 8'h00) begin errors++; $display("FAIL rmid_pre_rcvd got=%h want=00", rcvd); end
        to_xmit = 8'hF0;
        ss = 2'b10;
        miso = 1'b1;
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({ss_n, sclk, busy} !== 4'b1100) begin errors++; $display("FAIL rmid_abort ss_n,sclk,busy got=%b%b%b want=1100", ss_n, sclk, busy); end
        checks++; if (rcvd !== 8'h00) begin errors++; $display("FAIL rmid_rcvd got=%h want=00", rcvd); end
        rst = 1'b0;
        @(negedge clk);
        do_xfer(8'h9C, 2'b10, 8'h3B, 0, 0);
        checks++; if (rcvd !== 8'h3B || obs_lat != LATENCY) begin errors++; $display("FAIL rmid_recover rcvd=%h lat=%0d want=3b %0d", rcvd, obs_lat, LATENCY); end
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_slave0();
        test_slave1();
        test_ignored();
        test_hold_and_ss11();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
